fetch_unit: RTL

Instruction fetch stage that sits directly upstream of decode. Holds the fetch PC and issues one word request at a time to instruction memory. Buffers returned instructions with their PCs in a small queue and presents them to decode over a valid/ready handshake. A redirect from execute (branch/jump) flushes the queue, squashes any in-flight response and restarts fetch at the new target.

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage feeding decode. Holds the fetch PC and keeps at most
// one word request outstanding to instruction memory. Returned words are
// buffered with their PCs in a small queue and handed to decode over a
// valid/ready handshake. A redirect from execute flushes the queue, squashes
// any in-flight response and restarts fetch at the new target.
//
// Parameters:
//   RESET_PC  fetch PC loaded on reset
//   DEPTH     instruction queue entries (power of two, >= 2)
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   imem_req_valid/ready/addr       word request to instruction memory
//   imem_rsp_valid/data             memory response (no backpressure)
//   redirect_valid/pc               branch/jump restart from execute
//   id_valid/ready/instr/pc         queue head presented to decode
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int             AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(DEPTH);

    // IDLE: nothing outstanding, WAIT: response will be kept,
    // DROP: response belongs to a squashed fetch and will be discarded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          req_fire;
    logic          push;
    logic          pop;

    // Handshake qualifiers. A response that coincides with a redirect is
    // dropped along with the rest of the flushed queue.
    assign req_fire = imem_req_valid & imem_req_ready;
    assign push     = (state == WAIT) & imem_rsp_valid & ~redirect_valid;
    assign pop      = id_valid & id_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (req_fire) state_next = WAIT;
            WAIT: begin
                if (imem_rsp_valid)      state_next = IDLE;
                else if (redirect_valid) state_next = DROP;
            end
            DROP: if (imem_rsp_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request is suppressed during a redirect cycle so the address seen by
    // memory is never the stale fall-through PC.
    always_comb begin
        imem_req_valid = (state == IDLE) & (count < DEPTH_CNT) & ~redirect_valid & ~rst;
        imem_req_addr  = rst ? RESET_PC : fetch_pc;
        id_valid       = (count != '0) & ~rst;
        id_instr       = id_valid ? q_instr[rd_ptr] : 32'h0;
        id_pc          = id_valid ? q_pc[rd_ptr]    : 32'h0;
    end

    // Fetch PC, outstanding-request PC and queue bookkeeping. A redirect
    // overrides any push/pop happening in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (req_fire) begin
                req_pc <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    count <= count + (AW+1)'(1);
                end else if (!push && pop) begin
                    count <= count - (AW+1)'(1);
                end
            end
        end
    end

    // Queue storage needs no reset; entries are only read while counted.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            q_pc[wr_ptr]    <= req_pc;
            q_instr[wr_ptr] <= imem_rsp_data;
        end
    end

endmodule
